// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount as 1000/500/100/50 notes,
// one note per handshake with the ejector, with greedy denomination pick
// and per-denomination stock tracking.
// Optional: define CHANGE_DISPENSER_TIMEOUT_EN to abort a note request
// that is not acknowledged within ACK_TIMEOUT cycles.
module change_dispenser #(
  parameter int INIT_1000   = 8,
  parameter int INIT_500    = 8,
  parameter int INIT_100    = 16,
  parameter int INIT_50     = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] amount,
  input  logic        restock,
  input  logic        note_ack,
  output logic        out_tk1000,
  output logic        out_tk500,
  output logic        out_tk100,
  output logic        out_tk50,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [13:0] remaining,
  output logic [13:0] dispensed,
  output logic [7:0]  stock_1000,
  output logic [7:0]  stock_500,
  output logic [7:0]  stock_100,
  output logic [7:0]  stock_50
);

  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, DONE, ERR} state_t;

  // Index 3 is the largest note; the greedy scan walks 3 down to 0.
  localparam logic [3:0][13:0] DEN  = {14'd1000, 14'd500, 14'd100, 14'd50};
  localparam logic [3:0][7:0]  INIT = {8'(INIT_1000), 8'(INIT_500),
                                       8'(INIT_100),  8'(INIT_50)};

  state_t           state, state_n;
  logic [3:0]       req, req_n;
  logic             busy_n, done_n, error_n;
  logic [13:0]      rem_n, disp_n;
  logic [3:0][7:0]  stk, stk_n;
  logic             found;

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
  logic [7:0] cnt, cnt_n;
`endif

  // State and all outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      remaining <= '0;
      dispensed <= '0;
      stk       <= INIT;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_n;
      req       <= req_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
      remaining <= rem_n;
      dispensed <= disp_n;
      stk       <= stk_n;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
      cnt       <= cnt_n;
`endif
    end
  end

  // Next-state and next-output logic; every register holds by default
  // except done, which is a single-cycle pulse.
  always_comb begin
    state_n = state;
    req_n   = req;
    busy_n  = busy;
    done_n  = 1'b0;
    error_n = error;
    rem_n   = remaining;
    disp_n  = dispensed;
    stk_n   = stk;
    found   = 1'b0;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    cnt_n   = cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          rem_n   = amount;
          disp_n  = '0;
          error_n = 1'b0;
          busy_n  = 1'b1;
          state_n = SELECT;
        end else if (restock) begin
          stk_n = INIT;
        end
      end
      SELECT: begin
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
        cnt_n = '0;
`endif
        if (remaining == '0) begin
          state_n = DONE;
        end else begin
          // Largest note that fits and is in stock; no backtracking.
          for (int i = 3; i >= 0; i--) begin
            if (!found && remaining >= DEN[i] && stk[i] != 8'd0) begin
              found    = 1'b1;
              req_n    = '0;
              req_n[i] = 1'b1;
            end
          end
          state_n = found ? ISSUE : ERR;
        end
      end
      ISSUE: begin
        if (note_ack) begin
          for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
              rem_n    = remaining - DEN[i];
              disp_n   = dispensed + DEN[i];
              stk_n[i] = stk[i] - 8'd1;
            end
          end
          req_n   = '0;
          state_n = SELECT;
        end
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
        else if (cnt == TO_LAST) begin
          // Ejector never answered: drop the request, book nothing.
          req_n   = '0;
          state_n = ERR;
        end else begin
          cnt_n = cnt + 8'd1;
        end
`endif
      end
      DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      ERR: begin
        error_n = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign out_tk1000 = req[3];
  assign out_tk500  = req[2];
  assign out_tk100  = req[1];
  assign out_tk50   = req[0];
  assign stock_1000 = stk[3];
  assign stock_500  = stk[2];
  assign stock_100  = stk[1];
  assign stock_50   = stk[0];

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed payouts against two dispensers (default
// stock, and one with a single 1000 note). Expected note sequences are
// queued before each payout and popped as the requests appear.
module tb_change_dispenser;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start   [2];
  logic        restock [2];
  logic        ack     [2];
  logic [13:0] amount  [2];
  wire  [3:0]  req     [2];
  wire         busy    [2];
  wire         done    [2];
  wire         error   [2];
  wire  [13:0] rem     [2];
  wire  [13:0] disp    [2];
  wire  [7:0]  s1000   [2];
  wire  [7:0]  s500    [2];
  wire  [7:0]  s100    [2];
  wire  [7:0]  s50     [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    change_dispenser #(
      .INIT_1000  ((g == 1) ? 1 : 8),
      .ACK_TIMEOUT(10)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start[g]),
      .amount    (amount[g]),
      .restock   (restock[g]),
      .note_ack  (ack[g]),
      .out_tk1000(req[g][3]),
      .out_tk500 (req[g][2]),
      .out_tk100 (req[g][1]),
      .out_tk50  (req[g][0]),
      .busy      (busy[g]),
      .done      (done[g]),
      .error     (error[g]),
      .remaining (rem[g]),
      .dispensed (disp[g]),
      .stock_1000(s1000[g]),
      .stock_500 (s500[g]),
      .stock_100 (s100[g]),
      .stock_50  (s50[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int den(input logic [3:0] r);
    case (r)
      4'b1000: return 1000;
      4'b0100: return 500;
      4'b0010: return 100;
      4'b0001: return 50;
      default: return -1;
    endcase
  endfunction

  task automatic stocks(input int u, input int a, input int b, input int c, input int d);
    check("stock_1000", s1000[u], a);
    check("stock_500",  s500[u],  b);
    check("stock_100",  s100[u],  c);
    check("stock_50",   s50[u],   d);
  endtask

  // One payout: acks each request one cycle after it appears, pops the
  // expected denomination, then checks the terminal status. inj != 0
  // pulses a second start of that amount while the payout is busy.
  task automatic pay(input int u, input int amt, input int inj,
                     input bit exp_done, input int exp_rem, input int exp_disp);
    int  first_c, last_ack, n0;
    bit  fin;
    n0 = exp_q.size(); first_c = -1; last_ack = -1; fin = 0;
    @(negedge clk); start[u] = 1'b1; amount[u] = 14'(amt);
    @(negedge clk); start[u] = 1'b0;
    check("busy_after_start", busy[u], 1);
    check("no_req_at_1cyc", req[u], 0);
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      if (inj != 0) begin
        start[u] = (c == 0);
        if (c == 0) amount[u] = 14'(inj);
      end
      if (req[u] != 4'b0 && !ack[u]) begin
        if (first_c < 0) first_c = c;
        if (exp_q.size() == 0) check("extra_req", den(req[u]), 0);
        else check("req_den", den(req[u]), exp_q.pop_front());
        ack[u] = 1'b1;
        last_ack = c;
      end else begin
        ack[u] = 1'b0;
      end
      if (done[u] || error[u]) begin
        fin = 1;
        check("done", done[u], exp_done);
        check("error", error[u], !exp_done);
        check("remaining", rem[u], exp_rem);
        check("dispensed", disp[u], exp_disp);
        check("busy_end", busy[u], 0);
        check("notes_left", exp_q.size(), 0);
        if (n0 > 0) begin
          check("first_req_latency", first_c, 0);
          if (exp_done) check("done_latency", c - last_ack, 3);
        end
      end
    end
    if (!fin) check("payout_timeout", 0, 1);
    @(negedge clk);
    check("done_pulse_len", done[u], 0);
    check("error_hold", error[u], !exp_done);
  endtask

  initial begin
    int hi;
    bit fin;
    for (int i = 0; i < 2; i++) begin
      start[i] = 0; restock[i] = 0; ack[i] = 0; amount[i] = '0;
    end
    #12;
    // reset state
    check("rst_req", req[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_error", error[0], 0);
    check("rst_rem", rem[0], 0);
    check("rst_disp", disp[0], 0);
    stocks(0, 8, 8, 16, 16);
    check("rst_stock_1000_u1", s1000[1], 1);
    @(negedge clk); rst = 1'b1;

    // full greedy sweep
    exp_q = {1000, 500, 100, 50};
    pay(0, 1650, 0, 1, 0, 1650);
    stocks(0, 7, 7, 15, 15);

    // non-multiple of 50: pays 250, leaves 25
    exp_q = {100, 100, 50};
    pay(0, 275, 0, 0, 25, 250);
    stocks(0, 7, 7, 13, 14);

    // restock in IDLE reloads; error stays held
    @(negedge clk); restock[0] = 1'b1;
    @(negedge clk); restock[0] = 1'b0;
    stocks(0, 8, 8, 16, 16);
    check("error_after_restock", error[0], 1);

    // zero amount: straight to done
    exp_q = {};
    pay(0, 0, 0, 1, 0, 0);

    // single 1000 note in stock: falls back to 500s
    exp_q = {1000, 500, 500};
    pay(1, 2000, 0, 1, 0, 2000);
    check("u1_stock_1000", s1000[1], 0);
    exp_q = {500, 500};
    pay(1, 1000, 0, 1, 0, 1000);
    check("u1_stock_500", s500[1], 4);

    // start while busy is ignored
    exp_q = {100, 100, 100};
    pay(0, 300, 600, 1, 0, 300);
    check("stock_100_after_300", s100[0], 13);

    // reset while a 1000 note is requested
    @(negedge clk); start[0] = 1'b1; amount[0] = 14'd1000;
    @(negedge clk); start[0] = 1'b0;
    @(negedge clk); check("req_1000", req[0], 4'b1000);
    @(negedge clk); check("req_1000_held", req[0], 4'b1000);
    #2 rst = 1'b0;
    #1;
    check("midrst_req", req[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_done", done[0], 0);
    stocks(0, 8, 8, 16, 16);
    @(negedge clk); rst = 1'b1;

    // unanswered request
    @(negedge clk); start[0] = 1'b1; amount[0] = 14'd500;
    @(negedge clk); start[0] = 1'b0;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    hi = 0; fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (req[0] == 4'b0100) hi++;
      if (error[0]) fin = 1;
    end
    check("to_finished", fin, 1);
    check("to_req_cycles", hi, 10);
    check("to_error", error[0], 1);
    check("to_remaining", rem[0], 500);
    check("to_dispensed", disp[0], 0);
    check("to_stock_500", s500[0], 8);
`else
    hi = 0; fin = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req[0] == 4'b0100) hi++;
    end
    check("wait_req_cycles", hi, 30);
    check("wait_busy", busy[0], 1);
    ack[0] = 1'b1;
    @(negedge clk); ack[0] = 1'b0;
    for (int c = 0; c < 10 && !fin; c++) begin
      @(negedge clk);
      if (done[0]) fin = 1;
    end
    check("wait_done", fin, 1);
    check("wait_stock_500", s500[0], 7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
